// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receives PS/2 keyboard frames, decodes scan-code set 2 make codes into
//   ASCII and queues one ASCII code per keystroke in a first-word-fall-through
//   FIFO for the game's character-hit logic.
//
//   Optional feature macro: PS2_SHIFT_UPPER_EN
//     defined   : shift turns letters into uppercase and digits into their
//                 US-layout shifted symbols; shift_held reports the flag.
//     undefined : shift is tracked internally but never alters the mapping;
//                 shift_held is tied to 0.
//
// Ports
//   clk        in   system clock (CLOCK_50)
//   rst_n      in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock line (asynchronous)
//   ps2_dat    in   raw PS/2 data line (asynchronous)
//   rd_en      in   pop the head entry; ignored when FIFO empty
//   ascii      out  FIFO head, 8'h00 when empty
//   valid      out  FIFO non-empty
//   overflow   out  sticky: a decoded key was dropped because FIFO was full
//   parity_err out  one-cycle pulse per frame rejected by parity or stop bit
//   shift_held out  a shift key is currently held down
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd_en,
  output logic [7:0] ascii,
  output logic       valid,
  output logic       overflow,
  output logic       parity_err,
  output logic       shift_held
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // Scan code -> {hit, ascii}; upper selects the shifted character set.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic upper);
    logic [7:0] a;
    logic       hit;
    hit = 1'b1;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      default: begin hit = 1'b0; a = 8'h00; end
    endcase
    if (upper && (a >= 8'h61) && (a <= 8'h7A)) begin
      a = a - 8'h20;
    end else if (upper && (a >= 8'h30) && (a <= 8'h39)) begin
      case (a)
        8'h30: a = 8'h29; 8'h31: a = 8'h21; 8'h32: a = 8'h40; 8'h33: a = 8'h23;
        8'h34: a = 8'h24; 8'h35: a = 8'h25; 8'h36: a = 8'h5E; 8'h37: a = 8'h26;
        8'h38: a = 8'h2A; 8'h39: a = 8'h28;
        default: a = a;
      endcase
    end else begin
      a = a;
    end
    return {hit, a};
  endfunction

  // ---------------- state ----------------
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    code_q, code_d;
  logic          perr_q, perr_d;
  logic          ext_q, ext_d, brk_q, brk_d, shift_q, shift_d;
  logic [7:0]    held_q, held_d;
  logic          push_q, push_d;
  logic [7:0]    push_data_q, push_data_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          ovf_q, ovf_d;

  logic          fall_s, bit_s, empty_s, full_s, pop_s, wr_s, upper_s;
  logic [8:0]    map_s;

`ifdef PS2_SHIFT_UPPER_EN
  assign upper_s    = shift_q;
  assign shift_held = shift_q;
`else
  assign upper_s    = 1'b0;
  assign shift_held = 1'b0;
`endif

  // Synchroniser, frame FSM and timeout next-state.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    fall_s     = clk_sync_q[2] & ~clk_sync_q[1];
    bit_s      = dat_sync_q[1];
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    strobe_d   = 1'b0;
    code_d     = code_q;
    perr_d     = 1'b0;
    if (fall_s) begin
      tmo_d = {TW{1'b0}};
      case (state_q)
        S_IDLE: begin
          if (!bit_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          sr_d = {bit_s, sr_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          par_d   = bit_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          // Odd parity: the 8 data bits plus parity bit must hold an odd count of ones.
          if (bit_s && (^{par_q, sr_q})) begin
            strobe_d = 1'b1;
            code_d   = sr_q;
          end else begin
            perr_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        tmo_d   = {TW{1'b0}};
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = {TW{1'b0}};
    end
  end

  // Scan-code decoder: prefix tracking, held-key repeat suppression, push request.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    map_s       = map_code(code_q, upper_s);
    if (strobe_q) begin
      if (code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q) begin
          held_d = held_q;
        end else if (brk_q) begin
          if (code_q == held_q) begin
            held_d = 8'h00;
          end else begin
            held_d = held_q;
          end
          if ((code_q == 8'h12) || (code_q == 8'h59)) begin
            shift_d = 1'b0;
          end else begin
            shift_d = shift_q;
          end
        end else if ((code_q == 8'h12) || (code_q == 8'h59)) begin
          shift_d = 1'b1;
        end else if (map_s[8]) begin
          // Same code as the held key is typematic repeat: suppressed.
          if (code_q != held_q) begin
            held_d      = code_q;
            push_d      = 1'b1;
            push_data_d = map_s[7:0];
          end else begin
            held_d = held_q;
          end
        end else begin
          held_d = code_q;
        end
      end
    end else begin
      push_d = 1'b0;
    end
  end

  // FIFO pointers, storage and sticky overflow; a pop frees room for a same-cycle push.
  always_comb begin
    empty_s  = (wr_ptr_q == rd_ptr_q);
    full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s    = rd_en & ~empty_s;
    wr_s     = push_q & (~full_s | pop_s);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (push_q & full_s & ~pop_s);
    if (wr_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_q;
      wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State registers; synchroniser resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 2'b11;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      sr_q        <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= {TW{1'b0}};
      strobe_q    <= 1'b0;
      code_q      <= 8'h00;
      perr_q      <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= 8'h00;
      shift_q     <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      wr_ptr_q    <= {(AW + 1){1'b0}};
      rd_ptr_q    <= {(AW + 1){1'b0}};
      ovf_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      strobe_q    <= strobe_d;
      code_q      <= code_d;
      perr_q      <= perr_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
    end
  end

  assign valid      = ~empty_s;
  assign ascii      = empty_s ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow   = ovf_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table-driven keystroke vectors
// plus hand-written sequences for latency, parity, typematic, extended codes,
// timeout, overflow, reset mid-frame and shift handling.
module tb_ps2_key_decoder;

  localparam int HALF = 10;   // clk cycles per PS/2 clock half-period
  localparam int TMO  = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] ascii;
  logic       valid, overflow, parity_err, shift_held;

  int checks = 0;
  int errors = 0;
  logic vhist [1:6];
  logic phist [1:6];

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_en(rd_en), .ascii(ascii), .valid(valid), .overflow(overflow),
    .parity_err(parity_err), .shift_held(shift_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       exp_valid;
    logic [7:0] exp_ascii;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; history of valid/parity_err recorded for 6 cycles after the stop-bit fall.
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    @(negedge clk); ps2_dat = ~bad_stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); @(negedge clk);
      vhist[i] = valid;
      phist[i] = parity_err;
    end
    repeat (HALF - 6) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(code, 1'b0, 1'b0);
  endtask

  task automatic pop();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  vec_t tbl [8];
  logic [7:0] ovf_codes [9];
  logic [7:0] ovf_ascii [9];
  logic [7:0] exp_shift_ascii;
  logic       exp_shift_held;

  initial begin
    tbl[0] = '{8'h1C, 1'b1, 8'h61};
    tbl[1] = '{8'h32, 1'b1, 8'h62};
    tbl[2] = '{8'h1A, 1'b1, 8'h7A};
    tbl[3] = '{8'h4D, 1'b1, 8'h70};
    tbl[4] = '{8'h45, 1'b1, 8'h30};
    tbl[5] = '{8'h16, 1'b1, 8'h31};
    tbl[6] = '{8'h29, 1'b1, 8'h20};
    tbl[7] = '{8'h76, 1'b0, 8'h00};   // Esc: unmapped
    ovf_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    ovf_ascii = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
`ifdef PS2_SHIFT_UPPER_EN
    exp_shift_ascii = 8'h41;
    exp_shift_held  = 1'b1;
`else
    exp_shift_ascii = 8'h61;
    exp_shift_held  = 1'b0;
`endif

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ascii", 32'(ascii), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    chk("reset_parity_err", 32'(parity_err), 32'h0);
    chk("reset_shift_held", 32'(shift_held), 32'h0);

    // First frame: valid rises exactly 5 clk edges after the stop fall is driven.
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("lat_valid_n2", 32'(vhist[4]), 32'h0);
    chk("lat_valid_n3", 32'(vhist[5]), 32'h1);
    chk("lat_no_perr", 32'(phist[3]), 32'h0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("first_ascii", 32'(ascii), 32'h61);
    pop();
    chk("first_single_push", 32'(valid), 32'h0);
    chk("empty_ascii", 32'(ascii), 32'h00);

    // Table-driven keystrokes.
    for (int i = 0; i < 8; i++) begin
      key(tbl[i].code);
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_ascii", i), 32'(ascii), 32'(tbl[i].exp_ascii));
      if (valid) pop();
      chk($sformatf("tbl%0d_drained", i), 32'(valid), 32'h0);
    end

    // Bad parity and bad stop bit: one-cycle pulse at N+1, nothing pushed.
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("perr_before", 32'(phist[2]), 32'h0);
    chk("perr_pulse", 32'(phist[3]), 32'h1);
    chk("perr_after", 32'(phist[4]), 32'h0);
    chk("perr_no_push", 32'(valid), 32'h0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("stop_err_pulse", 32'(phist[3]), 32'h1);
    chk("stop_err_no_push", 32'(valid), 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("after_perr_ascii", 32'(ascii), 32'h61);
    pop();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Typematic: 1C 1C 1C F0 1C 1C -> two pushes.
    for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("typ_first", 32'(ascii), 32'h61);
    pop();
    chk("typ_second_valid", 32'(valid), 32'h1);
    chk("typ_second", 32'(ascii), 32'h61);
    pop();
    chk("typ_only_two", 32'(valid), 32'h0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Extended code never emits; following space does.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("ext_no_push", 32'(valid), 32'h0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("ext_then_space", 32'(ascii), 32'h20);
    pop();
    chk("ext_only_one", 32'(valid), 32'h0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);

    // Timeout abandons a partial frame; the next full frame decodes cleanly.
    for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (TMO + 50) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("tmo_no_perr", 32'(phist[3]), 32'h0);
    chk("tmo_recover", 32'(ascii), 32'h20);
    pop();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);

    // Nine keystrokes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("ovf_not_yet", 32'(overflow), 32'h0);
      key(ovf_codes[i]);
    end
    chk("ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), 32'(ascii), 32'(ovf_ascii[i]));
      pop();
    end
    chk("ovf_drained", 32'(valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Reset mid-frame clears everything, including sticky overflow.
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_ovf", 32'(overflow), 32'h0);
    chk("rst_mid_valid", 32'(valid), 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("rst_mid_recover", 32'(ascii), 32'h61);
    pop();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Shift: 12, 1C, F0 1C, F0 12.
    send_frame(8'h12, 1'b0, 1'b0);
    chk("shift_down", 32'(shift_held), 32'(exp_shift_held));
    chk("shift_no_push", 32'(valid), 32'h0);
    key(8'h1C);
    chk("shift_ascii", 32'(ascii), 32'(exp_shift_ascii));
    chk("shift_still", 32'(shift_held), 32'(exp_shift_held));
    pop();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    chk("shift_up", 32'(shift_held), 32'h0);
    chk("shift_one_push", 32'(valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
